multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Main sequencing FSM for the multicycle RV32I datapath (subset: lw, sw, R-type add/sub/and/or, addi/andi/ori, beq).
//  Drives datapath mux selects, register/PC/IR write enables, memory request handshake and the 2-bit ALU_OP
//  consumed by ALU_CONTROL. One instruction at a time; no pipelining. Adds memory-wait timeout and retired-instr counter.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles waiting on mem_ready in a memory state; 0 = timeout disabled
//  CNT_WIDTH    32  width of instret counter
// PORTS
//  clk         in   1          single clock, rising edge
//  rst         in   1          synchronous reset, active-high
//  opcode      in   7          instruction[6:0] from IR (valid from DECODE onward)
//  zero        in   1          ALU zero flag
//  mem_ready   in   1          memory completes current access this cycle
//  mem_req     out  1          memory access request, held until mem_ready
//  mem_write   out  1          access is a write (only with mem_req)
//  adr_src     out  1          memory address: 0=PC, 1=ALUOut
//  ir_write    out  1          load IR (and OldPC) this cycle
//  pc_write    out  1          load PC this cycle
//  reg_write   out  1          register file write enable
//  result_src  out  2          00=ALUOut, 01=mem data, 10=ALU result (direct)
//  alu_src_a   out  2          00=PC, 01=OldPC, 10=rs1 reg A
//  alu_src_b   out  2          00=rs2 reg B, 01=immediate, 10=constant 4
//  ALU_OP      out  2          00=add, 01=sub, 10=decode funct (to ALU_CONTROL)
//  fault       out  1          sticky: illegal opcode or memory timeout
//  instret     out  CNT_WIDTH  count of retired instructions
//  state_dbg   out  4          current state encoding
// BEHAVIOUR
//  - Moore outputs decoded from state; exceptions: ir_write/pc_write gated by mem_ready (FETCH) or zero (BEQ).
//  - Unlisted outputs are 0 in every state. While rst=1: state<=FETCH, counter/timer/instret/fault <=0, all outputs 0.
//  - Encodings: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4 MEMWRITE=5 EXECR=6 EXECI=7 ALUWB=8 BEQ=9 FAULT=15.
//  - FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, ALU_OP=00, result_src=10; wait for mem_ready;
//    in mem_ready cycle ir_write=1, pc_write=1 (PC<=PC+4) -> DECODE.
//  - DECODE: alu_src_a=01, alu_src_b=01, ALU_OP=00 (branch target into ALUOut). Next by opcode:
//    0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; other -> FAULT.
//  - MEMADR: alu_src_a=10, alu_src_b=01, ALU_OP=00; opcode 0000011 -> MEMREAD, else -> MEMWRITE.
//  - MEMREAD: mem_req=1, adr_src=1; mem_ready -> MEMWB. MEMWB: result_src=01, reg_write=1 -> FETCH.
//  - MEMWRITE: mem_req=1, mem_write=1, adr_src=1; mem_ready -> FETCH.
//  - EXECR: alu_src_a=10, alu_src_b=00, ALU_OP=10 -> ALUWB. EXECI: alu_src_a=10, alu_src_b=01, ALU_OP=10 -> ALUWB.
//  - ALUWB: result_src=00, reg_write=1 -> FETCH.
//  - BEQ: alu_src_a=10, alu_src_b=00, ALU_OP=01, result_src=00, pc_write=zero -> FETCH.
//  - FAULT: fault=1, all other outputs 0; stays until rst. fault register set on entry, cleared only by rst.
//  - Handshake: mem_req, adr_src, mem_write stable every cycle of a memory state until mem_ready; mem_ready
//    while mem_req=0 is ignored. mem_ready in first cycle of a memory state -> zero wait (1-cycle state).
//  - Timeout: wait counter clears on entry to FETCH/MEMREAD/MEMWRITE, increments each cycle mem_ready=0;
//    if MEM_TIMEOUT>0 and counter reaches MEM_TIMEOUT with mem_ready=0 -> FAULT next cycle. mem_ready in the
//    same cycle as the limit wins (normal transition).
//  - instret increments by 1 on each transition MEMWB->, MEMWRITE->, ALUWB->, BEQ-> FETCH; wraps modulo 2^CNT_WIDTH.
//  - CPI: R/I-type 4, beq 3, lw 5, sw 4 (zero memory wait states).
//  - rst mid-instruction: abort immediately, no pending write completes; next cycle FETCH.
// TESTING
//  - Reset: rst=1 2 cycles -> all outputs 0, state_dbg=0; release, mem_ready=1 -> ir_write=pc_write=1 in cycle 1.
//  - add (0110011), mem_ready=1 -> states 0,1,6,8,0; ALU_OP=10 in EXECR; reg_write=1 only in ALUWB; instret=1.
//  - lw with 3 wait cycles on MEMREAD -> mem_req=1,adr_src=1 held 4 cycles; MEMWB result_src=01,reg_write=1.
//  - beq zero=1 -> pc_write=1 in BEQ, ALU_OP=01; repeat zero=0 -> pc_write=0; both retire, instret+=2.
//  - opcode 1111111 in DECODE -> FAULT, fault=1 held 20 cycles until rst; instret unchanged.
//  - MEM_TIMEOUT=4, mem_ready=0 in FETCH -> FAULT after 4 wait cycles; mem_ready=1 on 4th cycle -> DECODE.

Source files
------------

// File: rtl/multicycle_control.sv
// multicycle_control: main sequencing FSM for a multicycle RV32I datapath
// (lw, sw, R-type, I-type ALU, beq), with memory-wait timeout and retired-instruction counter.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   opcode[6:0]              instruction[6:0] from IR, valid from DECODE onward
//   zero                     ALU zero flag, gates pc_write in BEQ
//   mem_ready                memory completes the current access this cycle
//   mem_req/mem_write        memory request and direction, held until mem_ready
//   adr_src                  memory address select: 0=PC, 1=ALUOut
//   ir_write, pc_write       IR/OldPC and PC load enables
//   reg_write                register file write enable
//   result_src[1:0]          00=ALUOut, 01=mem data, 10=ALU result
//   alu_src_a[1:0]           00=PC, 01=OldPC, 10=rs1
//   alu_src_b[1:0]           00=rs2, 01=immediate, 10=constant 4
//   ALU_OP[1:0]              00=add, 01=sub, 10=decode funct
//   fault                    sticky: illegal opcode or memory timeout
//   instret[CNT_WIDTH-1:0]   retired instruction count
//   state_dbg[3:0]           current state encoding
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           ALU_OP,
    output logic                 fault,
    output logic [CNT_WIDTH-1:0] instret,
    output logic [3:0]           state_dbg
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        FAULT    = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    // wait_cnt only needs to reach MEM_TIMEOUT-1 before the limit fires
    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t               state, state_n;
    logic [TW-1:0]        wait_cnt;
    logic                 fault_q;
    logic [CNT_WIDTH-1:0] count;
    logic                 timeout;
    logic                 retire;

    // wait_cnt holds the wait cycles already spent in this state, so this
    // fires on the MEM_TIMEOUT-th consecutive cycle without mem_ready
    assign timeout = (MEM_TIMEOUT > 0) && !mem_ready && (wait_cnt == TW'(MEM_TIMEOUT - 1));
    assign retire  = (state_n == FETCH) &&
                     (state == MEMWB || state == MEMWRITE || state == ALUWB || state == BEQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            wait_cnt <= '0;
            fault_q  <= 1'b0;
            count    <= '0;
        end else begin
            state    <= state_n;
            // any state change is an entry, which restarts the wait count
            wait_cnt <= (state_n == state) ? wait_cnt + 1'b1 : '0;
            if (state_n == FAULT) fault_q <= 1'b1;
            if (retire) count <= count + 1'b1;
        end
    end

    always_comb begin
        state_n    = state;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        ALU_OP     = 2'b00;
        case (state)
            FETCH: begin
                mem_req    = 1'b1;
                result_src = 2'b10;
                alu_src_b  = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                state_n    = mem_ready ? DECODE : timeout ? FAULT : FETCH;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                state_n   = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                            (opcode == OP_R) ? EXECR :
                            (opcode == OP_I) ? EXECI :
                            (opcode == OP_B) ? BEQ : FAULT;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_n   = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                state_n = mem_ready ? MEMWB : timeout ? FAULT : MEMREAD;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_n    = FETCH;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                state_n   = mem_ready ? FETCH : timeout ? FAULT : MEMWRITE;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                ALU_OP    = 2'b10;
                state_n   = ALUWB;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                ALU_OP    = 2'b10;
                state_n   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_n   = FETCH;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                ALU_OP    = 2'b01;
                pc_write  = zero;
                state_n   = FETCH;
            end
            FAULT:   state_n = FAULT;
            default: state_n = FAULT;
        endcase
        // reset aborts the current instruction at once: nothing is requested or written
        if (rst) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            adr_src    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            result_src = 2'b00;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            ALU_OP     = 2'b00;
        end
    end

    assign fault     = fault_q & ~rst;
    assign instret   = rst ? '0 : count;
    assign state_dbg = rst ? 4'd0 : state;
endmodule
